// File: rtl/add_sub_pkg.sv
// Shared types and constants for the nibble-serial subtractor controller.
package add_sub_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Counter must hold 0..nibbles-1; never narrower than one bit.
    function automatic int cnt_width(input int nibbles);
        int w;
        w = $clog2(nibbles);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/ADD_SUB_SUB_4bit.sv
// 4-bit borrow-lookahead subtractor slice: diff = a - b - bin, bout = borrow out.
module ADD_SUB_SUB_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       bin,
    output logic [3:0] diff,
    output logic       bout
);

    logic [3:0] g_s;
    logic [3:0] p_s;
    logic [3:0] c_s;

    // A bit generates a borrow when a=0,b=1 and passes one through when a==b.
    assign g_s = ~a & b;
    assign p_s = ~(a ^ b);

    assign c_s[0] = bin;
    assign c_s[1] = g_s[0] | (p_s[0] & bin);
    assign c_s[2] = g_s[1] | (p_s[1] & g_s[0]) | (p_s[1] & p_s[0] & bin);
    assign c_s[3] = g_s[2] | (p_s[2] & g_s[1]) | (p_s[2] & p_s[1] & g_s[0])
                  | (p_s[2] & p_s[1] & p_s[0] & bin);
    assign bout   = g_s[3] | (p_s[3] & g_s[2]) | (p_s[3] & p_s[2] & g_s[1])
                  | (p_s[3] & p_s[2] & p_s[1] & g_s[0])
                  | (p_s[3] & p_s[2] & p_s[1] & p_s[0] & bin);

    assign diff = a ^ b ^ c_s;

endmodule

// File: rtl/add_sub_nibble_seq_sub.sv
// Nibble-serial A - B - Bin controller: one 4-bit slice reused over WIDTH/4 cycles.
module add_sub_nibble_seq_sub
    import add_sub_pkg::*;
#(
    parameter int WIDTH = 24
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_clear,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_bin,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_bout,
    output logic             o_zero,
    output logic             o_busy
);

    localparam int NIBBLES = WIDTH / NIBBLE_W;
    localparam int CNT_W   = cnt_width(NIBBLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NIBBLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    if ((WIDTH % NIBBLE_W) != 0 || WIDTH < 8) begin : g_bad_width
        $error("add_sub_nibble_seq_sub: WIDTH must be a multiple of 4 and >= 8");
    end

    state_e           state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_r;
    logic [WIDTH-1:0] diff_r;
    logic [CNT_W-1:0] cnt_r;
    logic             borrow_r;
    logic             bout_r;
    logic             zero_r;
    logic             valid_r;
    logic             ready_r;
    logic             busy_r;

    logic [3:0]       slice_diff_s;
    logic             slice_bout_s;
    logic [WIDTH-1:0] res_next_s;

    ADD_SUB_SUB_4bit u_slice (
        .a    (a_sh_r[3:0]),
        .b    (b_sh_r[3:0]),
        .bin  (borrow_r),
        .diff (slice_diff_s),
        .bout (slice_bout_s)
    );

    // Result fills from the top so the first (least significant) nibble ends at bit 0.
    assign res_next_s = {slice_diff_s, res_r[WIDTH-1:NIBBLE_W]};

    // Controller FSM, datapath shift registers and registered outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r  <= IDLE;
            a_sh_r   <= '0;
            b_sh_r   <= '0;
            res_r    <= '0;
            diff_r   <= '0;
            cnt_r    <= '0;
            borrow_r <= 1'b0;
            bout_r   <= 1'b0;
            zero_r   <= 1'b0;
            valid_r  <= 1'b0;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
        end else if (i_clear) begin
            state_r  <= IDLE;
            a_sh_r   <= '0;
            b_sh_r   <= '0;
            res_r    <= '0;
            diff_r   <= '0;
            cnt_r    <= '0;
            borrow_r <= 1'b0;
            bout_r   <= 1'b0;
            zero_r   <= 1'b0;
            valid_r  <= 1'b0;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (i_valid && ready_r) begin
                        a_sh_r   <= i_a;
                        b_sh_r   <= i_b;
                        borrow_r <= i_bin;
                        cnt_r    <= '0;
                        state_r  <= RUN;
                        ready_r  <= 1'b0;
                        busy_r   <= 1'b1;
                    end
                end
                RUN: begin
                    a_sh_r   <= a_sh_r >> NIBBLE_W;
                    b_sh_r   <= b_sh_r >> NIBBLE_W;
                    res_r    <= res_next_s;
                    borrow_r <= slice_bout_s;
                    if (cnt_r == CNT_LAST) begin
                        state_r <= DONE;
                        diff_r  <= res_next_s;
                        bout_r  <= slice_bout_s;
                        zero_r  <= (res_next_s == '0);
                        valid_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state_r <= IDLE;
                        valid_r <= 1'b0;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    valid_r <= 1'b0;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready = ready_r;
    assign o_valid = valid_r;
    assign o_diff  = diff_r;
    assign o_bout  = bout_r;
    assign o_zero  = zero_r;
    assign o_busy  = busy_r;

endmodule

// File: tb/tb_add_sub_nibble_seq_sub.sv
// Bench for add_sub_nibble_seq_sub at WIDTH 24, 8 and 32 against a plain-arithmetic model.
module tb_add_sub_nibble_seq_sub;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        clear;
    logic        valid_s [3];
    logic        irdy_s  [3];
    logic [31:0] a_s     [3];
    logic [31:0] b_s     [3];
    logic        bin_s   [3];
    logic        ordy_s  [3];
    logic        oval_s  [3];
    logic        bout_s  [3];
    logic        zero_s  [3];
    logic        busy_s  [3];
    logic [31:0] diff_s  [3];
    logic [23:0] d24;
    logic [7:0]  d8;
    logic [31:0] d32;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit rand_en [3];

    add_sub_nibble_seq_sub #(.WIDTH(24)) u_dut24 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_valid(valid_s[0]),
        .o_ready(ordy_s[0]), .i_a(a_s[0][23:0]), .i_b(b_s[0][23:0]), .i_bin(bin_s[0]),
        .o_valid(oval_s[0]), .i_ready(irdy_s[0]), .o_diff(d24), .o_bout(bout_s[0]),
        .o_zero(zero_s[0]), .o_busy(busy_s[0]));

    add_sub_nibble_seq_sub #(.WIDTH(8)) u_dut8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_valid(valid_s[1]),
        .o_ready(ordy_s[1]), .i_a(a_s[1][7:0]), .i_b(b_s[1][7:0]), .i_bin(bin_s[1]),
        .o_valid(oval_s[1]), .i_ready(irdy_s[1]), .o_diff(d8), .o_bout(bout_s[1]),
        .o_zero(zero_s[1]), .o_busy(busy_s[1]));

    add_sub_nibble_seq_sub #(.WIDTH(32)) u_dut32 (
        .i_clk(clk), .i_rst_n(rst_n), .i_clear(clear), .i_valid(valid_s[2]),
        .o_ready(ordy_s[2]), .i_a(a_s[2]), .i_b(b_s[2]), .i_bin(bin_s[2]),
        .o_valid(oval_s[2]), .i_ready(irdy_s[2]), .o_diff(d32), .o_bout(bout_s[2]),
        .o_zero(zero_s[2]), .o_busy(busy_s[2]));

    assign diff_s[0] = {8'h00, d24};
    assign diff_s[1] = {24'h000000, d8};
    assign diff_s[2] = d32;

    function automatic int wid(input int i);
        return (i == 0) ? 24 : ((i == 1) ? 8 : 32);
    endfunction

    // Reference: {borrow, diff} of unsigned A - B - Bin modulo 2^w.
    function automatic logic [32:0] ref_sub(input int w, input logic [31:0] a,
                                            input logic [31:0] b, input logic bin);
        logic [33:0] m, av, bv, d;
        m  = (34'd1 << w) - 34'd1;
        av = {2'b00, a} & m;
        bv = {2'b00, b} & m;
        d  = (av - bv - {33'd0, bin}) & m;
        return {(av < (bv + {33'd0, bin})), d[31:0]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    // Scoreboard: pend[i] is whether instance i holds an operation after the next edge.
    bit          pend [3];
    int          acc  [3];
    logic [32:0] expv [3];

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            string p;
            bit    ev;
            p = $sformatf("w%0d", wid(i));
            if (!rst_n) begin
                chk({p, "_rst_ready"}, 32'(ordy_s[i]), 32'd1);
                chk({p, "_rst_valid"}, 32'(oval_s[i]), 32'd0);
                chk({p, "_rst_diff"},  diff_s[i],      32'd0);
                chk({p, "_rst_bout"},  32'(bout_s[i]), 32'd0);
                chk({p, "_rst_zero"},  32'(zero_s[i]), 32'd0);
                chk({p, "_rst_busy"},  32'(busy_s[i]), 32'd0);
                pend[i] = 1'b0;
            end else begin
                ev = pend[i] && ((cyc - acc[i]) >= wid(i) / 4);
                chk({p, "_valid"}, 32'(oval_s[i]), 32'(ev));
                chk({p, "_ready"}, 32'(ordy_s[i]), 32'(!pend[i]));
                chk({p, "_busy"},  32'(busy_s[i]), 32'(pend[i]));
                if (ev && oval_s[i]) begin
                    chk({p, "_diff"}, diff_s[i],      expv[i][31:0]);
                    chk({p, "_bout"}, 32'(bout_s[i]), 32'(expv[i][32]));
                    chk({p, "_zero"}, 32'(zero_s[i]), 32'(expv[i][31:0] == 32'd0));
                end
                if (clear) begin
                    pend[i] = 1'b0;
                end else if (!pend[i] && valid_s[i]) begin
                    pend[i] = 1'b1;
                    acc[i]  = cyc + 1;
                    expv[i] = ref_sub(wid(i), a_s[i], b_s[i], bin_s[i]);
                end else if (ev && irdy_s[i]) begin
                    pend[i] = 1'b0;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        for (int i = 0; i < 3; i++) begin
            if (rand_en[i]) irdy_s[i] = 1'($urandom_range(0, 1));
        end
    end

    task automatic wait_ready(input int i);
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (ordy_s[i]) return;
        end
        chk($sformatf("w%0d_accept_timeout", wid(i)), 32'd0, 32'd1);
    endtask

    // Call at posedge+1; returns on the negedge where o_valid is first seen.
    task automatic op24(input logic [31:0] a, input logic [31:0] b, input logic bin,
                        input logic [31:0] ed, input logic eb, input logic ez, input string tag);
        int lat;
        a_s[0] = a; b_s[0] = b; bin_s[0] = bin; valid_s[0] = 1'b1;
        wait_ready(0);
        @(posedge clk); #1;
        valid_s[0] = 1'b0;
        lat = 0;
        forever begin
            @(negedge clk);
            if (oval_s[0]) break;
            lat++;
            if (lat > 40) break;
        end
        chk({tag, "_latency"}, 32'(lat), 32'd6);
        chk({tag, "_diff"},    {8'h00, d24}, ed);
        chk({tag, "_bout"},    32'(bout_s[0]), 32'(eb));
        chk({tag, "_zero"},    32'(zero_s[0]), 32'(ez));
    endtask

    task automatic rand_ops(input int i, input int n);
        for (int k = 0; k < n; k++) begin
            int waits;
            @(posedge clk); #1;
            case ($urandom_range(0, 3))
                0: begin a_s[i] = $urandom; b_s[i] = $urandom; end
                1: begin a_s[i] = $urandom; b_s[i] = a_s[i]; end
                2: begin a_s[i] = 32'd0; b_s[i] = $urandom_range(0, 3); end
                default: begin a_s[i] = 32'hFFFF_FFFF; b_s[i] = $urandom; end
            endcase
            bin_s[i]   = 1'($urandom_range(0, 1));
            valid_s[i] = 1'b1;
            wait_ready(i);
            @(posedge clk); #1;
            valid_s[i] = 1'b0;
            waits = 0;
            forever begin
                @(negedge clk);
                if (oval_s[i] && irdy_s[i]) break;
                waits++;
                if (waits > 200) begin
                    chk($sformatf("w%0d_done_timeout", wid(i)), 32'd0, 32'd1);
                    break;
                end
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        for (int i = 0; i < 3; i++) begin
            valid_s[i] = 1'b0; irdy_s[i] = 1'b1; a_s[i] = 32'd0; b_s[i] = 32'd0;
            bin_s[i] = 1'b0; rand_en[i] = 1'b0; pend[i] = 1'b0; acc[i] = 0;
            expv[i] = 33'd0;
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        @(posedge clk); #1;
        op24(32'h000010, 32'h000001, 1'b0, 32'h00000F, 1'b0, 1'b0, "basic");
        @(posedge clk); #1;
        op24(32'h000000, 32'h000001, 1'b0, 32'hFFFFFF, 1'b1, 1'b0, "underflow");
        @(posedge clk); #1;
        op24(32'h123456, 32'h123456, 1'b1, 32'hFFFFFF, 1'b1, 1'b0, "eq_bin1");
        @(posedge clk); #1;
        op24(32'h123456, 32'h123456, 1'b0, 32'h000000, 1'b0, 1'b1, "eq_bin0");

        // Backpressure then back-to-back.
        @(posedge clk); #1;
        irdy_s[0] = 1'b0;
        op24(32'h000001, 32'h000002, 1'b0, 32'hFFFFFF, 1'b1, 1'b0, "bp");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(oval_s[0]), 32'd1);
            chk("bp_hold_diff",  {8'h00, d24},   32'hFFFFFF);
            chk("bp_hold_ready", 32'(ordy_s[0]), 32'd0);
        end
        @(posedge clk); #1 irdy_s[0] = 1'b1;
        @(posedge clk); #1;
        chk("bp_idle_ready", 32'(ordy_s[0]), 32'd1);
        op24(32'h800000, 32'h000001, 1'b0, 32'h7FFFFF, 1'b0, 1'b0, "b2b");

        // Abort during RUN.
        @(posedge clk); #1;
        a_s[0] = 32'h00F000; b_s[0] = 32'h000123; bin_s[0] = 1'b0; valid_s[0] = 1'b1;
        wait_ready(0);
        @(posedge clk); #1 valid_s[0] = 1'b0;
        repeat (2) @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk); #1 clear = 1'b0;
        chk("clr_ready", 32'(ordy_s[0]), 32'd1);
        chk("clr_busy",  32'(busy_s[0]), 32'd0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("clr_noval", 32'(oval_s[0]), 32'd0);
        end

        // Clear wins over an IDLE accept.
        @(posedge clk); #1;
        clear = 1'b1; valid_s[0] = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0; valid_s[0] = 1'b0;
        chk("clr_idle_busy", 32'(busy_s[0]), 32'd0);
        op24(32'hABCDEF, 32'h012345, 1'b1, 32'hAAAAA9, 1'b0, 1'b0, "after_clr");

        // Async reset mid-RUN.
        @(posedge clk); #1;
        a_s[0] = 32'h000050; b_s[0] = 32'h000020; bin_s[0] = 1'b0; valid_s[0] = 1'b1;
        wait_ready(0);
        @(posedge clk); #1 valid_s[0] = 1'b0;
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(ordy_s[0]), 32'd1);
        chk("arst_valid", 32'(oval_s[0]), 32'd0);
        chk("arst_diff",  {8'h00, d24},   32'd0);
        chk("arst_busy",  32'(busy_s[0]), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(posedge clk); #1;
        op24(32'h000100, 32'h0000FF, 1'b0, 32'h000001, 1'b0, 1'b0, "after_rst");

        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) rand_en[i] = 1'b1;
        fork
            rand_ops(0, 200);
            rand_ops(1, 1000);
            rand_ops(2, 1000);
        join
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
